// File: rtl/scan_driver.sv
// ---------------------------------------------------------------------------
// scan_driver
//
// Multiplexed scan driver for a common-anode seven-segment bank. Each of the
// DIGITS digits owns a slot of TICK_DIV clock cycles. A slot opens with
// BLANK_CYCLES dark cycles so the previous anode can discharge before the
// next one is driven. After that the digit is lit for a brightness-dependent
// number of cycles (PWM), then stays dark for the rest of the slot.
// Segment data, the mask bit and the brightness are captured when the slot
// opens, so mid-slot changes only take effect on the next slot.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   seg_data     per-digit active-low segment bytes; digit k at [8k+7:8k]
//   digit_mask   1 enables digit k, 0 keeps its slot dark
//   brightness   PWM level; 0 is off, all-ones is fully on
//   an           active-low anode selects (registered, at most one low)
//   seg          active-low segment byte of the lit digit, 8'hFF when dark
//   digit_idx    digit whose slot the current outputs belong to
//   frame_start  one-cycle pulse on the outputs for slot cycle 0 of digit 0
// ---------------------------------------------------------------------------
module scan_driver #(
    parameter int DIGITS       = 4,
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 2000,
    parameter int DIM_BITS     = 4,
    localparam int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS*8-1:0]   seg_data,
    input  logic [DIGITS-1:0]     digit_mask,
    input  logic [DIM_BITS-1:0]   brightness,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_start
);

    localparam int S_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // Wide enough that brightness * STEP can never overflow.
    localparam int PROD_W = DIM_BITS + $clog2(TICK_DIV) + 1;
    localparam int STEP   = (TICK_DIV - BLANK_CYCLES) >> DIM_BITS;

    logic [S_W-1:0]      s_q, s_d;
    logic [IDX_W-1:0]    d_q, d_d;
    logic [7:0]          seg_lat_q, seg_lat_d;
    logic                mask_lat_q, mask_lat_d;
    logic [DIM_BITS-1:0] bright_lat_q, bright_lat_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    logic [IDX_W-1:0]    idx_q;
    logic                fs_q, fs_d;

    logic                slot_start;
    logic                slot_end;
    logic                in_blank;
    logic                lit;
    logic [PROD_W-1:0]   lit_len;
    logic [PROD_W-1:0]   lit_off;

    // Unpack the flat segment bus into one byte per digit.
    logic [7:0] seg_bytes [DIGITS];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_unpack
            assign seg_bytes[gi] = seg_data[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        slot_start = (s_q == '0);
        slot_end   = (s_q == S_W'(TICK_DIV - 1));

        s_d = slot_end ? '0 : s_q + S_W'(1);
        d_d = d_q;
        if (slot_end) begin
            d_d = (d_q == IDX_W'(DIGITS - 1)) ? '0 : d_q + IDX_W'(1);
        end

        // On slot cycle 0 the decision uses the freshly captured values, so
        // a zero-length blank still behaves as if they were already latched.
        seg_lat_d    = slot_start ? seg_bytes[d_q]  : seg_lat_q;
        mask_lat_d   = slot_start ? digit_mask[d_q] : mask_lat_q;
        bright_lat_d = slot_start ? brightness      : bright_lat_q;

        in_blank = (s_q < S_W'(BLANK_CYCLES));
        lit_len  = PROD_W'(bright_lat_d) * PROD_W'(STEP);
        lit_off  = PROD_W'(s_q) - PROD_W'(BLANK_CYCLES);

        // All-ones brightness is full on even when STEP truncates to zero.
        lit = mask_lat_d && (bright_lat_d != '0) && !in_blank &&
              ((&bright_lat_d) || (lit_off < lit_len));

        an_d  = lit ? ~(DIGITS'(1) << d_q) : '1;
        seg_d = lit ? seg_lat_d : 8'hFF;
        fs_d  = slot_start && (d_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q          <= '0;
            d_q          <= '0;
            seg_lat_q    <= '0;
            mask_lat_q   <= 1'b0;
            bright_lat_q <= '0;
            an_q         <= '1;
            seg_q        <= 8'hFF;
            idx_q        <= '0;
            fs_q         <= 1'b0;
        end else begin
            s_q          <= s_d;
            d_q          <= d_d;
            seg_lat_q    <= seg_lat_d;
            mask_lat_q   <= mask_lat_d;
            bright_lat_q <= bright_lat_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            idx_q        <= d_q;
            fs_q         <= fs_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign digit_idx   = idx_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_scan_driver
//
// Bench for scan_driver with DIGITS=4, TICK_DIV=16, BLANK_CYCLES=2,
// DIM_BITS=2 (STEP=3). A behavioural model derives the expected outputs from
// the cycle count since reset: slot = n/16, digit = slot%4, capture at
// slot cycle 0, lit window from the brightness rule. Scenario tasks also
// check fixed expectations for the first slot, dimming, masking, mid-slot
// changes, mid-operation reset and scan invariants under random inputs.
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_scan_driver;

    localparam int BLANK = 2;
    localparam int STEP  = 3;
    localparam int SLOT  = 16;
    localparam int FRAME = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] seg_data = 32'hC0F9A4B0;
    logic [3:0]  digit_mask = 4'hF;
    logic [1:0]  brightness = 2'd3;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [1:0]  digit_idx;
    logic        frame_start;

    int checks = 0;
    int passes = 0;

    scan_driver #(
        .DIGITS      (4),
        .TICK_DIV    (16),
        .BLANK_CYCLES(2),
        .DIM_BITS    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_data   (seg_data),
        .digit_mask (digit_mask),
        .brightness (brightness),
        .an         (an),
        .seg        (seg),
        .digit_idx  (digit_idx),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    int unsigned m_n = 0;
    logic [7:0]  m_seg = 8'h00;
    logic        m_mask = 1'b0;
    int          m_br = 0;
    logic [3:0]  exp_an = 4'hF;
    logic [7:0]  exp_seg = 8'hFF;
    logic [1:0]  exp_idx = 2'd0;
    logic        exp_fs = 1'b0;

    always @(posedge clk) begin : model
        int  s;
        int  d;
        bit  lit;
        if (rst) begin
            m_n    = 0;
            m_seg  = 8'h00;
            m_mask = 1'b0;
            m_br   = 0;
            exp_an  <= 4'hF;
            exp_seg <= 8'hFF;
            exp_idx <= 2'd0;
            exp_fs  <= 1'b0;
        end else begin
            s = int'(m_n % SLOT);
            d = int'((m_n / SLOT) % 4);
            if (s == 0) begin
                m_seg  = seg_data[8*d +: 8];
                m_mask = digit_mask[d];
                m_br   = int'(brightness);
            end
            lit = m_mask && (m_br != 0) && (s >= BLANK) &&
                  ((m_br == 3) || ((s - BLANK) < m_br * STEP));
            exp_an  <= lit ? (4'hF & ~(4'b0001 << d)) : 4'hF;
            exp_seg <= lit ? m_seg : 8'hFF;
            exp_idx <= 2'(d);
            exp_fs  <= (m_n % FRAME == 0);
            m_n = m_n + 1;
        end
    end

    // Waits (bounded) for the falling edge on which frame_start is high.
    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [3:0] e_an;
        logic [7:0] e_seg;
        logic [1:0] e_idx;
        rst = 1'b1;
        seg_data = 32'hC0F9A4B0;
        digit_mask = 4'hF;
        brightness = 2'd3;
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 4'hF || seg !== 8'hFF || digit_idx !== 2'd0 || frame_start !== 1'b0)
            $display("FAIL reset_state an=%b seg=%h idx=%0d fs=%b required an=1111 seg=ff idx=0 fs=0",
                     an, seg, digit_idx, frame_start);
        else passes++;
        rst = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            e_an  = (k >= 3 && k <= 16) ? 4'b1110 : (k == 19) ? 4'b1101 : 4'hF;
            e_seg = (k >= 3 && k <= 16) ? 8'hB0   : (k == 19) ? 8'hA4   : 8'hFF;
            e_idx = (k <= 16) ? 2'd0 : 2'd1;
            checks++;
            if (an !== e_an || seg !== e_seg || digit_idx !== e_idx || frame_start !== (k == 1))
                $display("FAIL first_slot edge=%0d an=%b seg=%h idx=%0d fs=%b required an=%b seg=%h idx=%0d fs=%b",
                         k, an, seg, digit_idx, frame_start, e_an, e_seg, e_idx, (k == 1));
            else passes++;
        end
        $display("test_reset: first slot sequence checked");
    endtask

    task automatic test_dimming();
        bit ok;
        int lit_cnt [4];
        for (int lvl = 1; lvl >= 0; lvl--) begin
            brightness = 2'(lvl);
            foreach (lit_cnt[i]) lit_cnt[i] = 0;
            wait_fs(ok);
            checks++;
            if (!ok) $display("FAIL dim_wait_fs frame_start=%b required 1", frame_start);
            else passes++;
            for (int k = 0; k < FRAME; k++) begin
                if (k > 0) @(negedge clk);
                checks++;
                if (an !== exp_an || seg !== exp_seg || digit_idx !== exp_idx || frame_start !== exp_fs)
                    $display("FAIL dim_model k=%0d an=%b/%b seg=%h/%h idx=%0d/%0d fs=%b/%b",
                             k, an, exp_an, seg, exp_seg, digit_idx, exp_idx, frame_start, exp_fs);
                else passes++;
                if (an !== 4'hF) lit_cnt[digit_idx]++;
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (lit_cnt[i] != 3 * lvl)
                    $display("FAIL dim_lit_count level=%0d digit=%0d lit=%0d required %0d",
                             lvl, i, lit_cnt[i], 3 * lvl);
                else passes++;
            end
            $display("test_dimming: brightness=%0d lit cycles per digit %0d %0d %0d %0d",
                     lvl, lit_cnt[0], lit_cnt[1], lit_cnt[2], lit_cnt[3]);
        end
    endtask

    task automatic test_mask();
        bit ok;
        int lit_total = 0;
        brightness = 2'd3;
        digit_mask = 4'b0101;
        wait_fs(ok);
        wait_fs(ok);
        checks++;
        if (!ok) $display("FAIL mask_wait_fs frame_start=%b required 1", frame_start);
        else passes++;
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (!(an === 4'hF || an === 4'b1110 || an === 4'b1011) || frame_start !== (k % FRAME == 0))
                $display("FAIL mask_pattern k=%0d an=%b fs=%b required an in {1111,1110,1011} fs=%b",
                         k, an, frame_start, (k % FRAME == 0));
            else passes++;
            checks++;
            if (an !== exp_an || seg !== exp_seg || digit_idx !== exp_idx || frame_start !== exp_fs)
                $display("FAIL mask_model k=%0d an=%b/%b seg=%h/%h idx=%0d/%0d fs=%b/%b",
                         k, an, exp_an, seg, exp_seg, digit_idx, exp_idx, frame_start, exp_fs);
            else passes++;
            if (an !== 4'hF) lit_total++;
        end
        checks++;
        if (lit_total != 4 * 14)
            $display("FAIL mask_lit_total lit=%0d required %0d", lit_total, 4 * 14);
        else passes++;
        digit_mask = 4'hF;
        $display("test_mask: lit cycles over two frames %0d", lit_total);
    endtask

    task automatic test_midslot();
        bit ok;
        int lit0 [2];
        logic [7:0] e_seg;
        lit0[0] = 0;
        lit0[1] = 0;
        brightness = 2'd3;
        digit_mask = 4'hF;
        seg_data = 32'hC0F9A4B0;
        wait_fs(ok);
        checks++;
        if (!ok) $display("FAIL midslot_wait_fs frame_start=%b required 1", frame_start);
        else passes++;
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (an !== exp_an || seg !== exp_seg || digit_idx !== exp_idx || frame_start !== exp_fs)
                $display("FAIL midslot_model k=%0d an=%b/%b seg=%h/%h idx=%0d/%0d fs=%b/%b",
                         k, an, exp_an, seg, exp_seg, digit_idx, exp_idx, frame_start, exp_fs);
            else passes++;
            if (digit_idx === 2'd0 && an === 4'b1110) begin
                lit0[k / FRAME]++;
                e_seg = (k < FRAME) ? 8'hB0 : 8'h92;
                checks++;
                if (seg !== e_seg)
                    $display("FAIL midslot_seg k=%0d seg=%h required %h", k, seg, e_seg);
                else passes++;
            end
            if (k == 4) begin
                brightness = 2'd1;
                seg_data[7:0] = 8'h92;
            end
        end
        checks++;
        if (lit0[0] != 14 || lit0[1] != 3)
            $display("FAIL midslot_lit digit0 lit=%0d then %0d required 14 then 3", lit0[0], lit0[1]);
        else passes++;
        $display("test_midslot: digit0 lit %0d then %0d cycles", lit0[0], lit0[1]);
    endtask

    task automatic test_mid_reset();
        bit ok;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        seg_data = 32'hC0F9A4B0;
        digit_mask = 4'hF;
        brightness = 2'd3;
        wait_fs(ok);
        wait_fs(ok);
        checks++;
        if (!ok) $display("FAIL midrst_wait_fs frame_start=%b required 1", frame_start);
        else passes++;
        // Counter now holds s=1 of digit 0; advance until it holds s=7 of digit 2.
        repeat (38) @(negedge clk);
        checks++;
        if (an !== 4'b1011 || digit_idx !== 2'd2)
            $display("FAIL midrst_pre an=%b idx=%0d required an=1011 idx=2", an, digit_idx);
        else passes++;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (an !== 4'hF || seg !== 8'hFF || digit_idx !== 2'd0 || frame_start !== 1'b0)
            $display("FAIL midrst_state an=%b seg=%h idx=%0d fs=%b required an=1111 seg=ff idx=0 fs=0",
                     an, seg, digit_idx, frame_start);
        else passes++;
        rst = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            e_an  = (k >= 3 && k <= 16) ? 4'b1110 : (k == 19) ? 4'b1101 : 4'hF;
            e_seg = (k >= 3 && k <= 16) ? 8'hB0   : (k == 19) ? 8'hA4   : 8'hFF;
            checks++;
            if (an !== e_an || seg !== e_seg || frame_start !== (k == 1))
                $display("FAIL midrst_replay edge=%0d an=%b seg=%h fs=%b required an=%b seg=%h fs=%b",
                         k, an, seg, frame_start, e_an, e_seg, (k == 1));
            else passes++;
        end
        $display("test_mid_reset: replay after reset checked");
    endtask

    task automatic test_invariants();
        bit ok;
        int fs_seen = 0;
        logic [1:0] prev_idx;
        logic [1:0] nxt_idx;
        wait_fs(ok);
        checks++;
        if (!ok) $display("FAIL inv_wait_fs frame_start=%b required 1", frame_start);
        else passes++;
        prev_idx = digit_idx;
        for (int k = 0; k < 10 * FRAME; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if ($countones(~an) > 1 || frame_start !== (k % FRAME == 0))
                $display("FAIL inv_an_fs k=%0d an=%b fs=%b required <=1 low bit and fs=%b",
                         k, an, frame_start, (k % FRAME == 0));
            else passes++;
            if (digit_idx !== prev_idx) begin
                nxt_idx = prev_idx + 2'd1;
                checks++;
                if (digit_idx !== nxt_idx || (k % SLOT) != 0)
                    $display("FAIL inv_idx_seq k=%0d idx=%0d required %0d at slot boundary",
                             k, digit_idx, nxt_idx);
                else passes++;
                prev_idx = digit_idx;
            end
            checks++;
            if (an !== exp_an || seg !== exp_seg || digit_idx !== exp_idx || frame_start !== exp_fs)
                $display("FAIL inv_model k=%0d an=%b/%b seg=%h/%h idx=%0d/%0d fs=%b/%b",
                         k, an, exp_an, seg, exp_seg, digit_idx, exp_idx, frame_start, exp_fs);
            else passes++;
            if (frame_start === 1'b1) fs_seen++;
            if ($urandom_range(0, 7) == 0) begin
                seg_data   = $urandom;
                digit_mask = 4'($urandom_range(0, 15));
                brightness = 2'($urandom_range(0, 3));
            end
        end
        checks++;
        if (fs_seen != 10)
            $display("FAIL inv_fs_count frames=%0d required 10", fs_seen);
        else passes++;
        $display("test_invariants: %0d frames scanned with random inputs", fs_seen);
    endtask

    initial begin
        test_reset();
        test_dimming();
        test_mask();
        test_midslot();
        test_mid_reset();
        test_invariants();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/scan_driver.md
# scan_driver

Parametrised multiplexed display scan driver for common-anode seven-segment banks. It time-slices DIGITS digits and produces active-low anode selects plus the matching active-low segment byte. Each slot carries anti-ghosting blanking, PWM brightness control and per-digit enable masking. It sits between the display-data formatter and the board pins, and replaces the fixed 4-digit, 1 ms anode rotator.

## Interface
Parameters:
- DIGITS, 4, number of digits scanned; legal range 1..16
- TICK_DIV, 100000, clock cycles per digit slot (1 ms at 100 MHz); must exceed BLANK_CYCLES
- BLANK_CYCLES, 2000, dark cycles at the start of every slot (ghosting guard)
- DIM_BITS, 4, brightness width; legal value ≥1

Ports:
- clk  input  1  system clock; one clock domain
- rst  input  1  synchronous, active-high reset
- seg_data  input  DIGITS*8  per-digit segment bytes, active-low; digit k is at bits [8k+7:8k]; bit 7 is dp
- digit_mask  input  DIGITS  1 enables digit k; 0 keeps it dark
- brightness  input  DIM_BITS  0 is off; all-ones is full on
- an  output  DIGITS  anode selects, active-low; at most one bit is low
- seg  output  8  segment byte of the lit digit, active-low; 8'hFF when dark
- digit_idx  output  max(1,$clog2(DIGITS))  slot index that the outputs belong to
- frame_start  output  1  one-cycle pulse that marks slot cycle 0 of digit 0

## Operation
Slot counter s:
- Counts 0..TICK_DIV-1.
- At TICK_DIV-1 it wraps to 0, and digit index d advances.
- d wraps from DIGITS-1 to 0.

Slot-start latching:
- When s==0, the block latches seg_data byte d, digit_mask[d] and brightness.
- These inputs are ignored for the rest of the slot, so mid-slot changes take effect at the next slot.

Phases within each slot:
- BLANK: while s < BLANK_CYCLES, an is all-ones and seg is 8'hFF.
- LIT: the digit is lit when all three hold:
  - the latched mask bit is 1
  - the latched brightness is non-zero
  - either the latched brightness is all-ones, or (s − BLANK_CYCLES) < brightness × STEP
- STEP is (TICK_DIV − BLANK_CYCLES) >> DIM_BITS, computed at elaboration.
- DARK: every other cycle of the slot; same outputs as BLANK.

Output values when lit:
- an[d] = 0; all other an bits = 1.
- seg = latched byte.

Arithmetic:
- The lit-length product is evaluated at a width of DIM_BITS + $clog2(TICK_DIV) + 1, so it cannot overflow.
- If STEP is 0, only brightness all-ones lights the digit.

Scan behaviour under masking:
- Masked digits still consume their slot; the scan rate is independent of the mask.
- If the mask is all zero, an stays all-ones, and scanning and frame_start continue.

Reset:
- Applied synchronously at any time, including mid-slot.
- On the next edge: s=0, d=0, an=all-ones, seg=8'hFF, digit_idx=0, frame_start=0, and all latched values are cleared.

## Timing
- s, d and every output update on the rising edge of clk.
- an, seg, digit_idx and frame_start are registered. Each reflects the decision for the counter value held before the edge, so there is 1 cycle of latency from s.
- After rst deasserts, the first edge produces the outputs for s=0 of digit 0, with frame_start=1.
- frame_start is high for exactly one cycle per DIGITS×TICK_DIV cycles.
- digit_idx changes only on the edge that produces the outputs for s=0; it is never mid-slot.
- Between two different digits, an passes through all-ones for at least BLANK_CYCLES cycles, so no two anode bits are ever low together.
- No combinational path exists from any input to any output.

## Test plan
All scenarios use DIGITS=4, TICK_DIV=16, BLANK_CYCLES=2, DIM_BITS=2, which gives STEP=3.

1. Reset and first slot.
   - Stimulus: rst for 3 cycles, then release; mask=4'hF, brightness=3, seg_data=32'h_C0F9A4B0.
   - Required response:
     - First edge after release: frame_start=1, an=4'hF.
     - an=4'b1110 and seg=8'hB0 appear on the 3rd edge and hold for 14 cycles.
     - Digit 1 (an=1101, seg=8'hA4) follows after a 2-cycle all-ones gap.
2. Dimming.
   - Stimulus: brightness=1.
   - Required response: each digit is lit for exactly 3 cycles per 16-cycle slot.
   - Stimulus: brightness=0.
   - Required response: an stays 4'hF for a whole frame.
3. Mask.
   - Stimulus: mask=4'b0101.
   - Required response: only an=1110 and an=1011 ever appear; the frame period stays 64 cycles.
4. Mid-slot changes.
   - Stimulus: during digit 0's lit phase, change brightness 3→1 and seg_data byte 0.
   - Required response: the current slot is unaffected; the changes appear when digit 0 is next scanned.
5. Mid-operation reset.
   - Stimulus: assert rst at s=7 of digit 2.
   - Required response: next edge gives an=4'hF, seg=8'hFF, digit_idx=0; after release, the sequence matches scenario 1.
6. Invariant checks, run over 10 frames.
   - Required response:
     - Count of zero bits in an is never above 1.
     - frame_start occurs every 64 cycles.
     - digit_idx follows 0,1,2,3,0.
